msk_rnd_prng: RTL and testbench

- Seeded pseudo-random source that sits directly upstream of the masked AND gadgets and drives their `rnd` inputs.
- Per gadget it provides d*(d-1)/2 fresh bits per consumed cycle, for N_GADGETS gadgets in parallel.
- Gadgets sample `rnd` at latency 0, so `rnd_out` is registered and stable for the whole cycle in which `rnd_valid` is high.
- A valid/ready handshake lets the datapath advance the stream only when gadgets actually consume randomness.

---
 rtl/msk_prng_pkg.sv | 27 ++
 rtl/msk_lfsr_unroll.sv | 24 ++
 rtl/msk_rnd_prng.sv | 122 ++++++++++++
 tb/tb_msk_rnd_prng.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/msk_prng_pkg.sv
// Shared definitions for the masking-randomness PRNG.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: LFSR width and feedback taps, FSM state enum, per-gadget bit count.
package msk_prng_pkg;

  localparam int LFSR_W = 64;

  // Feedback taps of the 64-bit Fibonacci LFSR (x^64 + x^63 + x^61 + x^60 + 1).
  localparam int TAP0 = 63;
  localparam int TAP1 = 62;
  localparam int TAP2 = 60;
  localparam int TAP3 = 59;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } prng_state_e;

  // Fresh random bits one masked AND gadget of d shares needs per cycle.
  function automatic int n_rnd(input int d);
    return (d * (d - 1)) / 2;
  endfunction

endpackage

// File: rtl/msk_lfsr_unroll.sv
// Combinational unroll of the 64-bit Fibonacci LFSR by STEPS single steps.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to register o_s.
// Ports: i_s = current state, o_s = state after STEPS steps.
module msk_lfsr_unroll
  import msk_prng_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [LFSR_W-1:0] i_s,
  output logic [LFSR_W-1:0] o_s
);

  logic [LFSR_W-1:0] w_acc;

  always_comb begin
    w_acc = i_s;
    for (int k = 0; k < STEPS; k++) begin
      w_acc = {w_acc[LFSR_W-2:0], w_acc[TAP0] ^ w_acc[TAP1] ^ w_acc[TAP2] ^ w_acc[TAP3]};
    end
    o_s = w_acc;
  end

endmodule

// File: rtl/msk_rnd_prng.sv
// Seeded LFSR source of fresh randomness for N_GADGETS masked AND gadgets.
// Latency: rnd_out is the registered LFSR low word; a handshake shows the next word one cycle later.
// Backpressure: the stream advances only on rnd_valid & rnd_ready; otherwise rnd_out holds.
// Ports: clk/rst (sync, active-high); seed_in/seed_valid/seed_ready two-word seed load
//        (low word first); reseed restarts seeding; rnd_out/rnd_valid/rnd_ready output
//        stream (gadget g uses slice [g*n_rnd(d) +: n_rnd(d)]); busy during LOAD and WARM.
module msk_rnd_prng
  import msk_prng_pkg::*;
#(
  parameter  int d         = 2,    // shares per variable, >= 2
  parameter  int N_GADGETS = 1,
  parameter  int WARMUP    = 128,  // single steps discarded after seeding
  localparam int RND_W     = N_GADGETS * n_rnd(d)  // must stay <= 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seed_in,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             reseed,
  output logic [RND_W-1:0] rnd_out,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy
);

  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

  prng_state_e       r_state;
  logic [LFSR_W-1:0] r_s;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_seed_rdy;
  logic              r_rnd_vld;
  logic              r_busy;

  logic [LFSR_W-1:0] w_step1;
  logic [LFSR_W-1:0] w_adv;
  logic [LFSR_W-1:0] w_seed;

  // Warm-up discards one step per cycle; a consumed word moves the state by
  // exactly RND_W steps so no output bit is ever handed out twice.
  msk_lfsr_unroll #(.STEPS(1)) u_step1 (
    .i_s (r_s),
    .o_s (w_step1)
  );

  msk_lfsr_unroll #(.STEPS(RND_W)) u_adv (
    .i_s (r_s),
    .o_s (w_adv)
  );

  assign w_seed = {seed_in, r_s[31:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s        <= '0;
      r_cnt      <= '0;
      r_seed_rdy <= 1'b1;
      r_rnd_vld  <= 1'b0;
      r_busy     <= 1'b0;
    end else if (reseed) begin
      // Any in-flight seed word or handshake is dropped; s is left for the
      // next seed to overwrite.
      r_state    <= IDLE;
      r_seed_rdy <= 1'b1;
      r_rnd_vld  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (seed_valid && r_seed_rdy) begin
            r_s[31:0] <= seed_in;
            r_state   <= LOAD;
            r_busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (seed_valid && r_seed_rdy) begin
            // An all-zero state would lock the LFSR forever.
            r_s        <= (w_seed == '0) ? LFSR_W'(1) : w_seed;
            r_cnt      <= CNT_W'(WARMUP);
            r_seed_rdy <= 1'b0;
            if (WARMUP == 0) begin
              r_state   <= RUN;
              r_rnd_vld <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_state   <= WARM;
            end
          end
        end
        WARM: begin
          r_s   <= w_step1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= RUN;
            r_rnd_vld <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        RUN: begin
          if (rnd_ready) begin
            r_s <= w_adv;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_seed_rdy <= 1'b1;
          r_rnd_vld  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign seed_ready = r_seed_rdy;
  assign rnd_valid  = r_rnd_vld;
  assign busy       = r_busy;
  assign rnd_out    = r_s[RND_W-1:0];

endmodule

// File: tb/tb_msk_rnd_prng.sv
// Directed self-checking bench for msk_rnd_prng.
// Three instances: u0 (d=2, WARMUP=0), u1 (d=3, WARMUP=0), u2 (d=3, WARMUP=4).
// Seed and reseed controls are shared; each instance has its own rnd_ready.
module tb_msk_rnd_prng;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_valid;
  logic        reseed;
  logic [31:0] seed_in0, seed_in12;
  logic        rdy0, rdy1, rdy2;

  logic        seed_ready0, seed_ready1, seed_ready2;
  logic [0:0]  rnd_out0;
  logic [2:0]  rnd_out1, rnd_out2;
  logic        rnd_valid0, rnd_valid1, rnd_valid2;
  logic        busy0, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msk_rnd_prng #(.d(2), .N_GADGETS(1), .WARMUP(0)) u0 (
    .clk(clk), .rst(rst), .seed_in(seed_in0), .seed_valid(seed_valid),
    .seed_ready(seed_ready0), .reseed(reseed), .rnd_out(rnd_out0),
    .rnd_valid(rnd_valid0), .rnd_ready(rdy0), .busy(busy0)
  );

  msk_rnd_prng #(.d(3), .N_GADGETS(1), .WARMUP(0)) u1 (
    .clk(clk), .rst(rst), .seed_in(seed_in12), .seed_valid(seed_valid),
    .seed_ready(seed_ready1), .reseed(reseed), .rnd_out(rnd_out1),
    .rnd_valid(rnd_valid1), .rnd_ready(rdy1), .busy(busy1)
  );

  msk_rnd_prng #(.d(3), .N_GADGETS(1), .WARMUP(4)) u2 (
    .clk(clk), .rst(rst), .seed_in(seed_in12), .seed_valid(seed_valid),
    .seed_ready(seed_ready2), .reseed(reseed), .rnd_out(rnd_out2),
    .rnd_valid(rnd_valid2), .rnd_ready(rdy2), .busy(busy2)
  );

  // Reference LFSR step: feedback is the parity of taps 63,62,60,59.
  function automatic logic [63:0] ref_step(input logic [63:0] s);
    logic nb;
    nb = ^(s & 64'hD800_0000_0000_0000);
    return {s[62:0], nb};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] m;
    int          busy_cnt;
    int          words;
    int          cyc;
    logic        took;

    rst        = 1'b1;
    seed_valid = 1'b0;
    reseed     = 1'b0;
    seed_in0   = '0;
    seed_in12  = '0;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    rdy2       = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_seed_ready0", seed_ready0, 1'b1);
    check("rst_rnd_valid0",  rnd_valid0,  1'b0);
    check("rst_busy0",       busy0,       1'b0);
    check("rst_seed_ready2", seed_ready2, 1'b1);
    check("rst_rnd_valid2",  rnd_valid2,  1'b0);
    check("rst_busy2",       busy2,       1'b0);

    // Seed: u0 gets all-zero words, u1/u2 get 0x00000001 then 0x00000000.
    seed_valid = 1'b1;
    seed_in0   = 32'h0;
    seed_in12  = 32'h1;
    tick();
    check("load_busy1",      busy1,       1'b1);
    check("load_seed_rdy1",  seed_ready1, 1'b1);
    seed_in0   = 32'h0;
    seed_in12  = 32'h0;
    tick();
    seed_valid = 1'b0;
    check("zero_seed_vld0",  rnd_valid0,  1'b1);
    check("zero_seed_out0",  rnd_out0,    1'b1);
    check("run_seed_rdy0",   seed_ready0, 1'b0);
    check("run_busy0",       busy0,       1'b0);
    check("seed1_vld1",      rnd_valid1,  1'b1);
    check("seed1_out1",      rnd_out1,    3'b001);
    check("warm_vld2",       rnd_valid2,  1'b0);
    check("warm_seed_rdy2",  seed_ready2, 1'b0);

    // u2 warm-up: busy counted from the cycle after the second seed word;
    // u1 must hold its word while rnd_ready is low.
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      check("hold_out1", rnd_out1, 3'b001);
      if (!busy2) break;
      busy_cnt++;
      tick();
    end
    check("warm_busy_cycles2", busy_cnt,   4);
    check("warm_done_vld2",    rnd_valid2, 1'b1);
    check("warm_done_out2",    rnd_out2,   3'b000);

    // One handshake on u0 and u1, then a second on u1 only.
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    tick();
    rdy0 = 1'b0;
    check("hs1_out0", rnd_out0,   1'b0);
    check("hs1_vld0", rnd_valid0, 1'b1);
    check("hs1_out1", rnd_out1,   3'b000);
    check("hs1_vld1", rnd_valid1, 1'b1);
    tick();
    rdy1 = 1'b0;
    check("hs2_out1", rnd_out1,   3'b000);
    check("hs2_vld1", rnd_valid1, 1'b1);

    // 1000 consumed words from u2 against the reference model, with
    // periodic stalls that must not move the stream.
    m     = 64'h10;
    words = 0;
    cyc   = 0;
    while (words < 1000 && cyc < 5000) begin
      check("stream_out2", rnd_out2,   m[2:0]);
      check("stream_vld2", rnd_valid2, 1'b1);
      took = ((cyc % 7) != 3);
      rdy2 = took;
      tick();
      if (took) begin
        m = ref_step(ref_step(ref_step(m)));
        words++;
      end
      cyc++;
    end
    check("stream_words2", words, 1000);

    // Reseed mid-RUN together with a handshake.
    rdy2   = 1'b1;
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    rdy2   = 1'b0;
    check("reseed_vld2",      rnd_valid2,  1'b0);
    check("reseed_seed_rdy2", seed_ready2, 1'b1);
    check("reseed_busy2",     busy2,       1'b0);
    check("reseed_vld1",      rnd_valid1,  1'b0);

    // seed_valid together with reseed: the word must be dropped.
    seed_valid = 1'b1;
    reseed     = 1'b1;
    seed_in12  = 32'h5;
    tick();
    reseed = 1'b0;
    check("drop_busy1",     busy1,       1'b0);
    check("drop_seed_rdy1", seed_ready1, 1'b1);
    // If the dropped word had been taken, this word would be the high half.
    seed_in12 = 32'h3;
    tick();
    check("reload_busy1", busy1,      1'b1);
    check("reload_vld1",  rnd_valid1, 1'b0);
    seed_in12 = 32'h0;
    tick();
    seed_valid = 1'b0;
    check("reload_vld1_run", rnd_valid1, 1'b1);
    check("reload_out1",     rnd_out1,   3'b011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
